// File: rtl/td4_core.sv
// TD4 4-bit execution core: one instruction per enabled clock, fetched
// combinationally from the program ROM at address PC.
module td4_core #(
    parameter logic [3:0] RESET_PC = 4'h0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic [3:0] rom_addr,
    input  logic [7:0] rom_data,
    input  logic [3:0] in_port,
    output logic [3:0] out_port,
    output logic [3:0] reg_a,
    output logic [3:0] reg_b,
    output logic       carry
);

    localparam logic [3:0] OP_ADD_A  = 4'b0000;
    localparam logic [3:0] OP_MOV_AB = 4'b0001;
    localparam logic [3:0] OP_IN_A   = 4'b0010;
    localparam logic [3:0] OP_MOV_AI = 4'b0011;
    localparam logic [3:0] OP_MOV_BA = 4'b0100;
    localparam logic [3:0] OP_ADD_B  = 4'b0101;
    localparam logic [3:0] OP_IN_B   = 4'b0110;
    localparam logic [3:0] OP_MOV_BI = 4'b0111;
    localparam logic [3:0] OP_OUT_B  = 4'b1001;
    localparam logic [3:0] OP_OUT_I  = 4'b1011;
    localparam logic [3:0] OP_JNC    = 4'b1110;
    localparam logic [3:0] OP_JMP    = 4'b1111;

    logic [3:0] pc_q, pc_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [3:0] out_q, out_d;
    logic       carry_q, carry_d;

    logic [3:0] opcode;
    logic [3:0] imm;
    logic [3:0] src;
    logic [4:0] sum;

    always_comb begin
        opcode = rom_data[7:4];
        imm    = rom_data[3:0];

        case (opcode)
            OP_ADD_A, OP_MOV_BA:            src = a_q;
            OP_ADD_B, OP_MOV_AB, OP_OUT_B:  src = b_q;
            OP_IN_A, OP_IN_B:               src = in_port;
            default:                        src = 4'h0;
        endcase

        sum = {1'b0, src} + {1'b0, imm};

        pc_d    = pc_q + 4'd1;
        a_d     = a_q;
        b_d     = b_q;
        out_d   = out_q;
        carry_d = sum[4];

        case (opcode)
            OP_ADD_A, OP_MOV_AB, OP_IN_A, OP_MOV_AI: a_d   = sum[3:0];
            OP_ADD_B, OP_MOV_BA, OP_IN_B, OP_MOV_BI: b_d   = sum[3:0];
            OP_OUT_B, OP_OUT_I:                      out_d = sum[3:0];
            OP_JMP: begin
                pc_d    = imm;
                carry_d = 1'b0;
            end
            // JNC looks at the flag left by the previous instruction, then clears it.
            OP_JNC: begin
                if (!carry_q) begin
                    pc_d = imm;
                end
                carry_d = 1'b0;
            end
            default: carry_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            a_q     <= 4'h0;
            b_q     <= 4'h0;
            out_q   <= 4'h0;
            carry_q <= 1'b0;
        end else if (en) begin
            pc_q    <= pc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            out_q   <= out_d;
            carry_q <= carry_d;
        end
    end

    assign rom_addr = pc_q;
    assign out_port = out_q;
    assign reg_a    = a_q;
    assign reg_b    = b_q;
    assign carry    = carry_q;

endmodule

// File: tb/tb_td4_core.sv
// Bench for td4_core: ROM array in the bench, an instruction-level reference
// model of the TD4, and a per-cycle comparison of all visible state.
module tb_td4_core;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] rom_addr;
    logic [7:0] rom_data;
    logic [3:0] in_port;
    logic [3:0] out_port;
    logic [3:0] reg_a;
    logic [3:0] reg_b;
    logic       carry;

    logic [7:0] rom [16];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (architectural view only)
    int m_pc, m_a, m_b, m_c, m_out;

    td4_core #(.RESET_PC(4'h0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .in_port  (in_port),
        .out_port (out_port),
        .reg_a    (reg_a),
        .reg_b    (reg_b),
        .carry    (carry)
    );

    assign rom_data = rom[rom_addr];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 0; m_a = 0; m_b = 0; m_c = 0; m_out = 0;
        end else if (en) begin
            int op, im, src, s, nxt;
            op  = int'(rom[m_pc][7:4]);
            im  = int'(rom[m_pc][3:0]);
            nxt = (m_pc + 1) % 16;
            if (op == 15) begin
                nxt = im;
                m_c = 0;
            end else if (op == 14) begin
                if (m_c == 0) nxt = im;
                m_c = 0;
            end else begin
                case (op)
                    0, 4:    src = m_a;
                    1, 5, 9: src = m_b;
                    2, 6:    src = int'(in_port);
                    default: src = 0;
                endcase
                s = src + im;
                case (op)
                    0, 1, 2, 3: m_a   = s % 16;
                    4, 5, 6, 7: m_b   = s % 16;
                    9, 11:      m_out = s % 16;
                    default: ;
                endcase
                m_c = (op == 8 || op == 10 || op == 12 || op == 13) ? 0 : s / 16;
            end
            m_pc = nxt;
        end
    end

    // ---------------- scoreboard: every cycle out of reset ----------------
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("pc",    int'(rom_addr), m_pc);
            check("reg_a", int'(reg_a),    m_a);
            check("reg_b", int'(reg_b),    m_b);
            check("carry", int'(carry),    m_c);
            check("out",   int'(out_port), m_out);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Reset asserted between edges; outputs must clear before any clock edge.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_pc",    int'(rom_addr), 0);
        check("rst_a",     int'(reg_a),    0);
        check("rst_b",     int'(reg_b),    0);
        check("rst_carry", int'(carry),    0);
        check("rst_out",   int'(out_port), 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic clear_rom(input logic [7:0] fill);
        for (int i = 0; i < 16; i++) rom[i] = fill;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int edges;
        int exp_out;
        int snap_pc, snap_a, snap_b, snap_c, snap_out;

        rst_n   = 1'b0;
        en      = 1'b1;
        in_port = 4'h0;
        clear_rom(8'h80);

        // Counting program: OUT Im k at k, JMP 0 at 15
        for (int k = 0; k < 15; k++) rom[k] = 8'hB0 | 8'(k);
        rom[15] = 8'hF0;
        do_reset();
        exp_out = 0;
        for (int n = 1; n <= 32; n++) begin
            run(1);
            if (((n - 1) % 16) < 15) exp_out = (n - 1) % 16;
            check("count_out",   int'(out_port), exp_out);
            check("count_pc",    int'(rom_addr), n % 16);
            check("count_carry", int'(carry),    0);
        end

        // PC=7 with A=5, then asynchronous reset
        clear_rom(8'h80);
        rom[0] = 8'h35;
        do_reset();
        run(7);
        check("pre_rst_pc", int'(rom_addr), 7);
        check("pre_rst_a",  int'(reg_a),    5);
        do_reset();

        // MOV A,F; ADD A,1; JNC 0; OUT Im 9; JMP 4
        clear_rom(8'h80);
        rom[0] = 8'h3F; rom[1] = 8'h01; rom[2] = 8'hE0; rom[3] = 8'hB9; rom[4] = 8'hF4;
        do_reset();
        run(2);
        check("ovf_a",     int'(reg_a), 0);
        check("ovf_carry", int'(carry), 1);
        run(1);
        check("jnc_fall_pc",    int'(rom_addr), 3);
        check("jnc_fall_carry", int'(carry),    0);
        run(1);
        check("out_imm9", int'(out_port), 9);

        // MOV A,3; ADD A,1; JNC 1; OUT Im F; JMP 4
        clear_rom(8'h80);
        rom[0] = 8'h33; rom[1] = 8'h01; rom[2] = 8'hE1; rom[3] = 8'hBF; rom[4] = 8'hF4;

        // Pause after five edges (pc=1, A=5), hold en low for five clocks
        do_reset();
        run(5);
        check("pause_pc", int'(rom_addr), 1);
        check("pause_a",  int'(reg_a),    5);
        snap_pc = m_pc; snap_a = m_a; snap_b = m_b; snap_c = m_c; snap_out = m_out;
        en = 1'b0;
        run(5);
        check("hold_pc",    int'(rom_addr), snap_pc);
        check("hold_a",     int'(reg_a),    snap_a);
        check("hold_b",     int'(reg_b),    snap_b);
        check("hold_carry", int'(carry),    snap_c);
        check("hold_out",   int'(out_port), snap_out);
        en = 1'b1;
        run(1);
        check("resume_a",  int'(reg_a),    6);
        check("resume_pc", int'(rom_addr), 2);

        // Full loop: MOV + 13 ADDs (4..F, then wrap) + 13 JNCs = 27 edges to exit
        do_reset();
        edges = 0;
        while (rom_addr != 4'h3 && edges < 100) begin
            run(1);
            edges++;
        end
        check("loop_edges", edges, 27);
        check("loop_a",     int'(reg_a), 0);
        check("loop_carry", int'(carry), 0);

        // IN B; OUT B; JMP 2
        clear_rom(8'h80);
        rom[0] = 8'h60; rom[1] = 8'h90; rom[2] = 8'hF2;
        in_port = 4'hA;
        do_reset();
        run(1);
        check("in_b", int'(reg_b), 10);
        run(1);
        check("out_b", int'(out_port), 10);
        in_port = 4'h5;
        run(3);
        check("out_hold", int'(out_port), 10);
        check("b_hold",   int'(reg_b),    10);

        // Random programs, inputs and enable, checked by the model every cycle
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 16; i++) rom[i] = 8'($urandom_range(0, 255));
            do_reset();
            for (int c = 0; c < 150; c++) begin
                en      = ($urandom_range(0, 3) != 0);
                in_port = 4'($urandom_range(0, 15));
                run(1);
            end
        end
        en = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
